// File: rtl/srt_div_arbiter_if.sv
// Bundle of requester, response and divider-core signals around srt_div_arbiter.
// master is the arbiter side; slave is the requesters, response consumer and core.
interface srt_div_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 64
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_dividend;
  logic [N_REQ*WIDTH-1:0] req_divisor;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_quo;
  logic [WIDTH-1:0]       rsp_rem;
  logic                   rsp_dbz;
  logic                   rsp_tmo;

  logic                   div_start;
  logic [WIDTH-1:0]       div_dividend;
  logic [WIDTH-1:0]       div_divisor;
  logic                   div_done;
  logic [WIDTH-1:0]       div_quo;
  logic [WIDTH-1:0]       div_rem;

  modport master (
    input  req_valid, req_dividend, req_divisor,
    output req_ready,
    output rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_dbz, rsp_tmo,
    input  rsp_ready,
    output div_start, div_dividend, div_divisor,
    input  div_done, div_quo, div_rem
  );

  modport slave (
    output req_valid, req_dividend, req_divisor,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_dbz, rsp_tmo,
    output rsp_ready,
    input  div_start, div_dividend, div_divisor,
    output div_done, div_quo, div_rem
  );
endinterface

// File: rtl/srt_div_arbiter.sv
// Round-robin sharing of one SRT divider core between N_REQ requesters, with
// local divide-by-zero handling and a watchdog on the core's completion.
module srt_div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  srt_div_arbiter_if.master bus
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_reg,    state_next;
  logic [ID_W-1:0]  rr_ptr_reg,   rr_ptr_next;
  logic [CNT_W-1:0] cnt_reg,      cnt_next;
  logic [ID_W-1:0]  id_reg,       id_next;
  logic [WIDTH-1:0] dividend_reg, dividend_next;
  logic [WIDTH-1:0] divisor_reg,  divisor_next;
  logic [WIDTH-1:0] quo_reg,      quo_next;
  logic [WIDTH-1:0] rem_reg,      rem_next;
  logic             dbz_reg,      dbz_next;
  logic             tmo_reg,      tmo_next;

  logic [ID_W-1:0]  cand_idx [N_REQ];
  logic [WIDTH-1:0] dvd_arr  [N_REQ];
  logic [WIDTH-1:0] dvs_arr  [N_REQ];
  logic             grant_any;
  logic [ID_W-1:0]  grant_idx;
  logic [N_REQ-1:0] grant_onehot;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;

  // cand_idx[k] is the requester examined k-th when searching upward from rr_ptr
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      logic [ID_W:0] sum;
      assign sum          = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                                       : sum[ID_W-1:0];
      assign dvd_arr[gi]  = bus.req_dividend[gi*WIDTH +: WIDTH];
      assign dvs_arr[gi]  = bus.req_divisor[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scanning from the far end lets the nearest valid candidate overwrite the rest
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[cand_idx[k]]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
  end

  assign grant_onehot = grant_any ? (N_REQ'(1) << grant_idx) : '0;
  assign sel_dividend = dvd_arr[grant_idx];
  assign sel_divisor  = dvs_arr[grant_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      cnt_reg      <= '0;
      id_reg       <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      dbz_reg      <= 1'b0;
      tmo_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      cnt_reg      <= cnt_next;
      id_reg       <= id_next;
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      quo_reg      <= quo_next;
      rem_reg      <= rem_next;
      dbz_reg      <= dbz_next;
      tmo_reg      <= tmo_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    cnt_next      = cnt_reg;
    id_next       = id_reg;
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    quo_next      = quo_reg;
    rem_next      = rem_reg;
    dbz_next      = dbz_reg;
    tmo_next      = tmo_reg;
    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          id_next       = grant_idx;
          rr_ptr_next   = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          dividend_next = sel_dividend;
          divisor_next  = sel_divisor;
          tmo_next      = 1'b0;
          if (sel_divisor == '0) begin
            // Resolved without the core: saturated quotient, dividend as remainder
            quo_next   = '1;
            rem_next   = sel_dividend;
            dbz_next   = 1'b1;
            state_next = RESP;
          end else begin
            dbz_next   = 1'b0;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        // A completion in the final watchdog cycle still counts as success
        if (bus.div_done) begin
          quo_next   = bus.div_quo;
          rem_next   = bus.div_rem;
          dbz_next   = 1'b0;
          tmo_next   = 1'b0;
          state_next = RESP;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          quo_next   = '0;
          rem_next   = '0;
          tmo_next   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gated by rst_n so the accept strobe is also silent while reset is held
  assign bus.req_ready    = (state_reg == IDLE && rst_n) ? grant_onehot : '0;
  assign bus.rsp_valid    = (state_reg == RESP);
  assign bus.rsp_id       = id_reg;
  assign bus.rsp_quo      = quo_reg;
  assign bus.rsp_rem      = rem_reg;
  assign bus.rsp_dbz      = dbz_reg;
  assign bus.rsp_tmo      = tmo_reg;
  assign bus.div_start    = (state_reg == ISSUE);
  assign bus.div_dividend = dividend_reg;
  assign bus.div_divisor  = divisor_reg;
endmodule

// File: tb/tb_srt_div_arbiter.sv
// Randomised and directed checks of srt_div_arbiter against a transaction-level
// model (grant order, response timing and results computed with plain arithmetic).
module tb_srt_div_arbiter;
  localparam int N_REQ   = 4;
  localparam int WIDTH   = 64;
  localparam int TIMEOUT = 64;

  typedef struct {
    int          id;
    logic [63:0] quo;
    logic [63:0] rem;
    logic        dbz;
    logic        tmo;
    int          cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  srt_div_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  srt_div_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // lat_sel: core latency for the next request, 0 means the core never answers
  int lat_sel = 33;
  int m_lat   = 33;
  bit spur_en = 1'b0;

  bit          m_busy = 1'b0;
  int          m_rr = 0, m_id = 0, m_start = -1, m_rsp_from = 0, g = 0;
  logic [63:0] m_a, m_b, m_quo, m_rem, exp_ready;
  logic        m_dbz, m_tmo;

  rsp_t rsp_log[$];
  int   grant_log[$];
  int   grant_cyc[$];
  int   start_cyc[$];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void bound_fail(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s cycle %0d: wait bound expired", nm, cyc);
  endfunction

  // ---------------- compare process / reference model ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_div_start", 64'(bus.div_start), 64'd0);
        chk("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        chk("rst_rsp_quo",   bus.rsp_quo,        64'd0);
        chk("rst_rsp_rem",   bus.rsp_rem,        64'd0);
        chk("rst_rsp_flags", 64'({bus.rsp_dbz, bus.rsp_tmo}), 64'd0);
        chk("rst_div_ops",   bus.div_dividend | bus.div_divisor, 64'd0);
        m_busy = 1'b0;
        m_rr   = 0;
      end else begin
        if (bus.div_start) start_cyc.push_back(cyc);
        if (bus.rsp_valid && bus.rsp_ready)
          rsp_log.push_back('{int'(bus.rsp_id), bus.rsp_quo, bus.rsp_rem,
                              bus.rsp_dbz, bus.rsp_tmo, cyc});
        if (!m_busy) begin
          g = -1;
          for (int k = 0; k < N_REQ; k++)
            if (g < 0 && bus.req_valid[(m_rr + k) % N_REQ]) g = (m_rr + k) % N_REQ;
          exp_ready = (g < 0) ? 64'd0 : (64'd1 << g);
          chk("req_ready", 64'(bus.req_ready), exp_ready);
          chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
          chk("idle_div_start", 64'(bus.div_start), 64'd0);
          if (g >= 0) begin
            grant_log.push_back(g);
            grant_cyc.push_back(cyc);
            m_busy = 1'b1;
            m_id   = g;
            m_rr   = (g + 1) % N_REQ;
            m_a    = bus.req_dividend[g*WIDTH +: WIDTH];
            m_b    = bus.req_divisor[g*WIDTH +: WIDTH];
            m_lat  = lat_sel;
            if (m_b == 64'd0) begin
              m_dbz = 1'b1; m_tmo = 1'b0; m_quo = '1; m_rem = m_a;
              m_start = -1; m_rsp_from = cyc + 1;
            end else begin
              m_dbz = 1'b0; m_start = cyc + 1;
              if (lat_sel > 0 && lat_sel <= TIMEOUT) begin
                m_tmo = 1'b0; m_quo = m_a / m_b; m_rem = m_a % m_b;
                m_rsp_from = m_start + lat_sel + 1;
              end else begin
                m_tmo = 1'b1; m_quo = 64'd0; m_rem = 64'd0;
                m_rsp_from = m_start + TIMEOUT + 1;
              end
            end
          end
        end else begin
          chk("busy_req_ready", 64'(bus.req_ready), 64'd0);
          chk("div_start", 64'(bus.div_start), 64'(cyc == m_start));
          if (m_start >= 0 && cyc >= m_start && cyc < m_rsp_from) begin
            chk("div_dividend", bus.div_dividend, m_a);
            chk("div_divisor",  bus.div_divisor,  m_b);
          end
          chk("rsp_valid", 64'(bus.rsp_valid), 64'(cyc >= m_rsp_from));
          if (cyc >= m_rsp_from) begin
            chk("rsp_id",  64'(bus.rsp_id),  64'(m_id));
            chk("rsp_quo", bus.rsp_quo,      m_quo);
            chk("rsp_rem", bus.rsp_rem,      m_rem);
            chk("rsp_dbz", 64'(bus.rsp_dbz), 64'(m_dbz));
            chk("rsp_tmo", 64'(bus.rsp_tmo), 64'(m_tmo));
            if (bus.rsp_ready) m_busy = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- divider core model ----------------
  initial begin
    int          core_cnt;
    bit          armed;
    logic [63:0] core_a, core_b;
    core_cnt = 0; armed = 1'b0; core_a = '0; core_b = '0;
    bus.div_done = 1'b0; bus.div_quo = '0; bus.div_rem = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        core_cnt = 0; armed = 1'b0;
        bus.div_done = 1'b0;
      end else begin
        bus.div_done = 1'b0;
        bus.div_quo  = {$urandom, $urandom};
        bus.div_rem  = {$urandom, $urandom};
        if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0) begin
            bus.div_done = 1'b1;
            bus.div_quo  = (core_b == 0) ? '1 : core_a / core_b;
            bus.div_rem  = (core_b == 0) ? core_a : core_a % core_b;
            armed = 1'b0;
          end
        end
        if (bus.rsp_valid) armed = 1'b0;
        if (bus.div_start) begin
          armed = 1'b1; core_a = bus.div_dividend; core_b = bus.div_divisor;
          core_cnt = (m_lat > 0) ? m_lat : 0;
        end
        // Stray completions while no divide is outstanding must be ignored
        if (spur_en && !armed && !bus.div_start && !bus.div_done && ($urandom % 4 == 0))
          bus.div_done = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic v);
    bus.req_dividend[i*WIDTH +: WIDTH] = a;
    bus.req_divisor[i*WIDTH +: WIDTH]  = b;
    bus.req_valid[i] = v;
  endtask

  task automatic send(input int i, input logic [63:0] a, input logic [63:0] b);
    int n;
    n = 0;
    set_req(i, a, b, 1'b1);
    do begin @(negedge clk); n++; end while (!bus.req_ready[i] && n < 400);
    if (!bus.req_ready[i]) bound_fail("accept_wait");
    tick();
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output rsp_t r);
    int n;
    n = 0;
    while (rsp_log.size() == 0 && n < 400) begin tick(); n++; end
    if (rsp_log.size() == 0) begin
      bound_fail("rsp_wait");
      r = '{0, 64'd0, 64'd0, 1'b0, 1'b0, 0};
    end else begin
      r = rsp_log.pop_front();
    end
  endtask

  task automatic clear_logs();
    rsp_log.delete(); grant_log.delete(); grant_cyc.delete(); start_cyc.delete();
  endtask

  task automatic rand_cycle();
    logic [63:0] a, b;
    int r;
    for (int i = 0; i < N_REQ; i++) begin
      a = ($urandom % 4 == 0) ? {$urandom, $urandom} : 64'($urandom % 5000);
      r = $urandom % 8;
      if (r == 0)      b = 64'd0;
      else if (r == 1) b = {$urandom, $urandom};
      else if (r == 2) b = 64'd1;
      else             b = 64'($urandom_range(1, 300));
      set_req(i, a, b, ($urandom % 3) != 0);
    end
    bus.rsp_ready = ($urandom % 4) != 0;
    r = $urandom % 32;
    if (r == 0)      lat_sel = 0;
    else if (r == 1) lat_sel = TIMEOUT;
    else if (r == 2) lat_sel = TIMEOUT + 1;
    else             lat_sel = $urandom_range(1, 40);
  endtask

  logic [63:0] rr_quo [N_REQ];
  logic [63:0] rr_rem [N_REQ];

  initial begin
    rsp_t r;
    int   n;
    bus.req_valid = '0; bus.req_dividend = '0; bus.req_divisor = '0;
    bus.rsp_ready = 1'b1;
    rr_quo[0] = 64'd10; rr_rem[0] = 64'd0;
    rr_quo[1] = 64'd14; rr_rem[1] = 64'd2;
    rr_quo[2] = 64'd20; rr_rem[2] = 64'd1;
    rr_quo[3] = 64'd30; rr_rem[3] = 64'd10;
    repeat (3) tick();
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    spur_en = 1'b1;

    // Round-robin with all four requesters continuously valid
    clear_logs();
    lat_sel = 5;
    set_req(0, 64'd50, 64'd5, 1'b1);
    set_req(1, 64'd100, 64'd7, 1'b1);
    set_req(2, 64'd81, 64'd4, 1'b1);
    set_req(3, 64'd1000, 64'd33, 1'b1);
    n = 0;
    while (grant_log.size() < 5 && n < 400) begin tick(); n++; end
    bus.req_valid = '0;
    if (grant_log.size() < 5) bound_fail("rr_grants");
    else begin
      chk("rr_g0", 64'(grant_log[0]), 64'd0);
      chk("rr_g1", 64'(grant_log[1]), 64'd1);
      chk("rr_g2", 64'(grant_log[2]), 64'd2);
      chk("rr_g3", 64'(grant_log[3]), 64'd3);
      chk("rr_g4", 64'(grant_log[4]), 64'd0);
    end
    for (int k = 0; k < 5; k++) begin
      wait_rsp(r);
      chk("rr_quo", r.quo, rr_quo[r.id % N_REQ]);
      chk("rr_rem", r.rem, rr_rem[r.id % N_REQ]);
    end

    // Single divide, 33-cycle core
    clear_logs();
    lat_sel = 33;
    send(0, 64'd987, 64'd6);
    wait_rsp(r);
    chk("single_id",  64'(r.id), 64'd0);
    chk("single_quo", r.quo, 64'd164);
    chk("single_rem", r.rem, 64'd3);
    chk("single_flags", 64'({r.dbz, r.tmo}), 64'd0);
    if (start_cyc.size() == 1 && grant_cyc.size() == 1) begin
      chk("single_issue_lat", 64'(start_cyc[0] - grant_cyc[0]), 64'd1);
      chk("single_rsp_lat",   64'(r.cyc - start_cyc[0]), 64'd34);
    end else bound_fail("single_start");

    // Divide by zero
    clear_logs();
    send(2, 64'd55, 64'd0);
    wait_rsp(r);
    chk("dbz_id",  64'(r.id), 64'd2);
    chk("dbz_quo", r.quo, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dbz_rem", r.rem, 64'd55);
    chk("dbz_flag", 64'({r.dbz, r.tmo}), 64'b10);
    chk("dbz_no_start", 64'(start_cyc.size()), 64'd0);
    if (grant_cyc.size() == 1) chk("dbz_rsp_lat", 64'(r.cyc - grant_cyc[0]), 64'd1);

    // Watchdog, then a normal divide
    clear_logs();
    lat_sel = 0;
    send(1, 64'd1234, 64'd5);
    wait_rsp(r);
    chk("tmo_flag", 64'({r.dbz, r.tmo}), 64'b01);
    chk("tmo_quo_rem", r.quo | r.rem, 64'd0);
    if (start_cyc.size() == 1) chk("tmo_lat", 64'(r.cyc - start_cyc[0]), 64'd65);
    lat_sel = 33;
    send(3, 64'd9, 64'd3);
    wait_rsp(r);
    chk("after_tmo_quo", r.quo, 64'd3);
    chk("after_tmo_rem", r.rem, 64'd0);
    chk("after_tmo_tmo", 64'(r.tmo), 64'd0);

    // Completion exactly on the last watchdog cycle wins; one later loses
    lat_sel = TIMEOUT;
    send(0, 64'd77, 64'd7);
    wait_rsp(r);
    chk("edge_done_wins", {r.quo[62:0], r.tmo}, {63'd11, 1'b0});
    lat_sel = TIMEOUT + 1;
    send(0, 64'd77, 64'd7);
    wait_rsp(r);
    chk("edge_late_tmo", 64'(r.tmo), 64'd1);

    // Back-pressure with another request pending
    clear_logs();
    lat_sel = 3;
    bus.rsp_ready = 1'b0;
    send(0, 64'd40, 64'd4);
    set_req(1, 64'd21, 64'd5, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin tick(); n++; end
    if (!bus.rsp_valid) bound_fail("bp_rsp");
    repeat (10) tick();
    chk("bp_quo", bus.rsp_quo, 64'd10);
    chk("bp_id", 64'(bus.rsp_id), 64'd0);
    chk("bp_no_accept", 64'(bus.req_ready), 64'd0);
    bus.rsp_ready = 1'b1;
    n = 0;
    while (grant_log.size() < 2 && n < 100) begin tick(); n++; end
    bus.req_valid[1] = 1'b0;
    if (grant_log.size() < 2 || rsp_log.size() < 1) bound_fail("bp_next_grant");
    else chk("bp_next_grant_gap", 64'(grant_cyc[1] - rsp_log[0].cyc), 64'd1);
    wait_rsp(r);
    wait_rsp(r);
    chk("bp_second_quo", r.quo, 64'd4);

    // Reset in the middle of WAIT
    clear_logs();
    lat_sel = 33;
    send(2, 64'd1000, 64'd10);
    n = 0;
    while (start_cyc.size() == 0 && n < 20) begin tick(); n++; end
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_div_dividend", bus.div_dividend, 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("midrst_no_rsp", 64'(rsp_log.size()), 64'd0);
    clear_logs();
    set_req(3, 64'd8, 64'd2, 1'b1);
    set_req(0, 64'd5, 64'd2, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.req_ready == '0 && n < 50);
    tick();
    bus.req_valid = '0;
    if (grant_log.size() == 0) bound_fail("midrst_grant");
    else chk("midrst_rr_ptr0", 64'(grant_log[0]), 64'd0);
    wait_rsp(r);
    chk("midrst_next_quo", r.quo, 64'd2);
    chk("midrst_next_rem", r.rem, 64'd1);

    // Randomised traffic
    repeat (2500) begin
      rand_cycle();
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    n = 0;
    while ((m_busy || bus.rsp_valid) && n < 300) begin tick(); n++; end
    if (m_busy || bus.rsp_valid) bound_fail("drain");
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
